// File: rtl/fabric_pkg.sv
// Shared fabric definitions: tag-merge elaboration messages, pointer width helper, tagged word type.
// Latency: n/a (package only).
// Backpressure: n/a.
package fabric_pkg;

  localparam string COMP_TAG_MERGE_NUM_IN     = "COMP_TAG_MERGE_NUM_IN: NUM_IN must be >= 2";
  localparam string COMP_TAG_MERGE_DATA_WIDTH = "COMP_TAG_MERGE_DATA_WIDTH: DATA_WIDTH must be >= 1";
  localparam string COMP_TAG_MERGE_TAG_WIDTH  = "COMP_TAG_MERGE_TAG_WIDTH: TAG_WIDTH must be >= 1 and 2**TAG_WIDTH >= NUM_IN";

  // Width of a pointer that indexes n entries; never narrower than 1 bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Default-width tagged word; modules with other widths build the same
  // layout locally from their own parameters.
  localparam int TAG_WORD_DATA_W = 32;
  localparam int TAG_WORD_TAG_W  = 4;

  typedef struct packed {
    logic [TAG_WORD_TAG_W-1:0]  tag;
    logic [TAG_WORD_DATA_W-1:0] value;
  } tag_word_t;

endpackage

// File: rtl/fabric_tag_merge_if.sv
// Handshake bundle for the N-to-1 tag merge: NUM_IN untagged inputs, one tagged output.
// Latency: n/a (wires only).
// Backpressure: valid/ready per input port and on the output.
// master = traffic source/sink side, slave = the merge block.
interface fabric_tag_merge_if #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic [NUM_IN-1:0]              in_valid;
  logic [NUM_IN-1:0]              in_ready;
  logic [NUM_IN*DATA_WIDTH-1:0]   in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_WIDTH+TAG_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fabric_rr_arbiter.sv
// Round-robin arbiter: scans req starting after the last granted port, wrapping.
// Latency: grant is combinational from req; pointer updates on the edge where advance is high.
// Backpressure: caller asserts advance only when the granted transfer actually happens.
// Ports: clk, rst_n (sync, active low), req, advance, grant_idx_in -> grant (one-hot), grant_idx.
module fabric_rr_arbiter
  import fabric_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int IDX_W = clog2_min1(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  input  logic [IDX_W-1:0]  grant_idx_in,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] rr_last_q, rr_last_d;
  logic [IDX_W-1:0] scan_idx;
  logic             hit;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    hit       = 1'b0;
    scan_idx  = '0;
    // k runs 1..NUM_IN so the last granted port is checked last.
    for (int k = 1; k <= NUM_IN; k++) begin
      scan_idx = IDX_W'((int'(rr_last_q) + k) % NUM_IN);
      if (!hit && req[scan_idx]) begin
        hit             = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (advance) rr_last_d = grant_idx_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_last_q <= IDX_W'(NUM_IN - 1);  // port 0 wins first
    else        rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/fabric_tag_merge.sv
// N-to-1 merge: round-robin picks an input, tags it cfg_tag_base+port, registers it.
// Latency: 1 cycle input handshake to out_valid, full throughput (no bubble).
// Backpressure: output register holds while out_valid && !out_ready; in_ready all-0 then.
// Ports: clk, rst_n (sync, active low), cfg_tag_base, bus (slave modport of fabric_tag_merge_if).
// Optional FABRIC_TAG_MERGE_STATS_EN adds stall_count[31:0] (saturating) and grant_count (16b/port, wrapping).
module fabric_tag_merge
  import fabric_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TAG_WIDTH-1:0]   cfg_tag_base,
  fabric_tag_merge_if.slave      bus
`ifdef FABRIC_TAG_MERGE_STATS_EN
  ,
  output logic [31:0]            stall_count,
  output logic [NUM_IN*16-1:0]   grant_count
`endif
);

  localparam int IDX_W = clog2_min1(NUM_IN);

  if (NUM_IN < 2) begin : g_chk_num_in
    $fatal(1, "%s", COMP_TAG_MERGE_NUM_IN);
  end
  if (DATA_WIDTH < 1) begin : g_chk_data_width
    $fatal(1, "%s", COMP_TAG_MERGE_DATA_WIDTH);
  end
  if ((TAG_WIDTH < 1) || ((2 ** TAG_WIDTH) < NUM_IN)) begin : g_chk_tag_width
    $fatal(1, "%s", COMP_TAG_MERGE_TAG_WIDTH);
  end

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] value;
  } word_t;

  word_t              out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               load;
  logic               xfer;
  logic [NUM_IN-1:0]  arb_grant;
  logic [IDX_W-1:0]   arb_idx;

  // Register may be refilled whenever it is empty or being drained this cycle.
  assign load = !out_valid_q || bus.out_ready;
  assign xfer = rst_n && load && (|arb_grant);

  fabric_rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (bus.in_valid),
    .advance      (xfer),
    .grant_idx_in (arb_idx),
    .grant        (arb_grant),
    .grant_idx    (arb_idx)
  );

  assign bus.in_ready  = (rst_n && load) ? arb_grant : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d.tag   = cfg_tag_base + TAG_WIDTH'(arb_idx);  // wraps mod 2**TAG_WIDTH
        out_data_d.value = bus.in_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef FABRIC_TAG_MERGE_STATS_EN
  logic [31:0]          stall_count_q, stall_count_d;
  logic [NUM_IN*16-1:0] grant_count_q, grant_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    grant_count_d = grant_count_q;
    if (out_valid_q && !bus.out_ready && (stall_count_q != '1))
      stall_count_d = stall_count_q + 32'd1;
    if (xfer)
      grant_count_d[arb_idx*16 +: 16] = grant_count_q[arb_idx*16 +: 16] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count_q <= '0;
      grant_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      grant_count_q <= grant_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_fabric_tag_merge.sv
// Bench for fabric_tag_merge: two instances (TAG_WIDTH 4 and 2) share one stimulus stream.
// Latency: n/a.
// Backpressure: out_ready driven by directed vectors.
module tb_fabric_tag_merge;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   base4;
  logic [1:0]   base2;
  logic [3:0]   tb_valid;
  logic [127:0] tb_data;
  logic         tb_ordy;

  int n_tests = 0;
  int n_fail  = 0;

  fabric_tag_merge_if #(.NUM_IN(4), .DATA_WIDTH(32), .TAG_WIDTH(4)) if4 ();
  fabric_tag_merge_if #(.NUM_IN(4), .DATA_WIDTH(32), .TAG_WIDTH(2)) if2 ();

  assign if4.in_valid  = tb_valid;
  assign if4.in_data   = tb_data;
  assign if4.out_ready = tb_ordy;
  assign if2.in_valid  = tb_valid;
  assign if2.in_data   = tb_data;
  assign if2.out_ready = tb_ordy;

`ifdef FABRIC_TAG_MERGE_STATS_EN
  logic [31:0] sc4, sc2;
  logic [63:0] gc4, gc2;
`endif

  fabric_tag_merge #(.NUM_IN(4), .DATA_WIDTH(32), .TAG_WIDTH(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_tag_base (base4),
    .bus          (if4)
`ifdef FABRIC_TAG_MERGE_STATS_EN
    ,
    .stall_count  (sc4),
    .grant_count  (gc4)
`endif
  );

  fabric_tag_merge #(.NUM_IN(4), .DATA_WIDTH(32), .TAG_WIDTH(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_tag_base (base2),
    .bus          (if2)
`ifdef FABRIC_TAG_MERGE_STATS_EN
    ,
    .stall_count  (sc2),
    .grant_count  (gc2)
`endif
  );

  // ---------------- reference model ----------------
  int          m_last  = 3;
  bit          m_valid = 1'b0;
  logic [31:0] m_val   = '0;
  logic [3:0]  m_tag4  = '0;
  logic [1:0]  m_tag2  = '0;

  // First valid port in rotation order after 'last', or -1 if none.
  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    if (!rst_n) return 4'b0000;
    if (m_valid && !tb_ordy) return 4'b0000;
    g = pick(tb_valid, m_last);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  always @(posedge clk) begin
    int g;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_val   = '0;
      m_tag4  = '0;
      m_tag2  = '0;
      m_last  = 3;
    end else if (!m_valid || tb_ordy) begin
      g = pick(tb_valid, m_last);
      if (g >= 0) begin
        m_valid = 1'b1;
        m_val   = tb_data[g*32 +: 32];
        m_tag4  = 4'((int'(base4) + g) % 16);
        m_tag2  = 2'((int'(base2) + g) % 4);
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_out_valid4", 64'(if4.out_valid), 64'(m_valid));
    check("model_out_data4",  64'(if4.out_data),  64'({m_tag4, m_val}));
    check("model_in_ready4",  64'(if4.in_ready),  64'(exp_ready()));
    check("model_out_valid2", 64'(if2.out_valid), 64'(m_valid));
    check("model_out_data2",  64'(if2.out_data),  64'({m_tag2, m_val}));
    check("model_in_ready2",  64'(if2.in_ready),  64'(exp_ready()));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    rst_n    = 1'b0;
    tb_valid = 4'b1111;
    tb_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tb_ordy  = 1'b1;
    base4    = 4'd0;
    base2    = 2'd0;

    // Reset held 3 cycles with all inputs valid.
    repeat (3) begin
      tick();
      check("rst_in_ready",  64'(if4.in_ready),  64'h0);
      check("rst_out_valid", 64'(if4.out_valid), 64'h0);
    end
    rst_n = 1'b1;

    // Round-robin back-to-back: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_out_valid", 64'(if4.out_valid), 64'h1);
      check("rr_data4", 64'(if4.out_data), 64'({4'(i % 4), 32'hA0 + 32'(i % 4)}));
      check("rr_data2", 64'(if2.out_data), 64'({2'(i % 4), 32'hA0 + 32'(i % 4)}));
    end

    // Backpressure on port 2.
    tb_valid         = 4'b0100;
    tb_data[95:64]   = 32'h55;
    tick();
    check("bp_first", 64'(if4.out_data), 64'h2_0000_0055);
    tb_data[95:64]   = 32'h66;
    tb_ordy          = 1'b0;
    repeat (5) begin
      tick();
      check("bp_hold_data",  64'(if4.out_data),  64'h2_0000_0055);
      check("bp_hold_valid", 64'(if4.out_valid), 64'h1);
      check("bp_in_ready",   64'(if4.in_ready),  64'h0);
    end
    tb_ordy = 1'b1;
    tick();
    check("bp_release", 64'(if4.out_data), 64'h2_0000_0066);
    tb_valid = 4'b0000;
    tick();
    check("bp_idle_valid", 64'(if4.out_valid), 64'h0);
    check("bp_idle_data",  64'(if4.out_data),  64'h2_0000_0066);

    // Tag wrap: base 15 (4-bit) and 3 (2-bit), port 1 -> tag 0.
    base4          = 4'd15;
    base2          = 2'd3;
    tb_valid       = 4'b0010;
    tb_data[63:32] = 32'h12;
    tick();
    check("wrap_data2", 64'(if2.out_data), 64'h0_0000_0012);
    check("wrap_data4", 64'(if4.out_data), 64'h0_0000_0012);
    tb_valid = 4'b0000;
    tick();

    // Sparse fairness: ports 1 and 3, rr_last=1.
    base4            = 4'd0;
    base2            = 2'd0;
    tb_data[63:32]   = 32'hB1;
    tb_data[127:96]  = 32'hB3;
    tb_valid         = 4'b1010;
    tick();
    check("sparse_g3a", 64'(if4.out_data), 64'h3_0000_00B3);
    tick();
    check("sparse_g1",  64'(if4.out_data), 64'h1_0000_00B1);
    tick();
    check("sparse_g3b", 64'(if4.out_data), 64'h3_0000_00B3);
    tb_valid = 4'b0000;
    tick();
    check("sparse_idle", 64'(if4.out_valid), 64'h0);

    // Mid-operation reset discards a held word.
    tb_valid       = 4'b0100;
    tb_data[95:64] = 32'h77;
    tick();
    check("mr_loaded", 64'(if4.out_data), 64'h2_0000_0077);
    tb_valid = 4'b0000;
    tb_ordy  = 1'b0;
    tick();
    check("mr_held", 64'(if4.out_valid), 64'h1);
    rst_n    = 1'b0;
    tb_valid = 4'b1111;
    tick();
    check("mr_valid", 64'(if4.out_valid), 64'h0);
    check("mr_data",  64'(if4.out_data),  64'h0);
    check("mr_ready", 64'(if4.in_ready),  64'h0);
    rst_n    = 1'b1;
    tb_valid = 4'b0000;
    tb_ordy  = 1'b1;
    tick();
    check("mr_no_emit", 64'(if4.out_valid), 64'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
